// File: rtl/mem_bridge_pkg.sv
// Shared types and defaults for the memory access bridge.
package mem_bridge_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// WAIT-cycle counter for the bridge abort path; present only when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr import mem_bridge_pkg::*; #(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/mem_access_bridge.sv
// Bridge from level-held controller strobes to a req/ack memory bus, one transaction at a time.
// Optional WAIT abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_bridge import mem_bridge_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              proto_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              proto_err_q, proto_err_d;
  logic              expire;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q != WAIT),
    .enable_i((state_q == WAIT) && !bus_ack_i),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (mem_read_i || mem_write_i) begin
          state_d     = WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write_i;
          bus_addr_d  = addr_i;
          bus_wdata_d = wdata_i;
          if (mem_read_i && mem_write_i) begin
            proto_err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        // Ack on the expiry cycle still completes normally.
        if (bus_ack_i) begin
          state_d = DONE;
          if (!bus_we_q) begin
            rdata_d = bus_rdata_i;
          end
        end else if (expire) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = (state_q == DONE);
  assign stall_o     = (state_q == WAIT);
  assign err_o       = err_q;
  assign proto_err_o = proto_err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_bridge.sv
// Self-checking bench for mem_access_bridge: vector table plus scoreboard, and hand-written corner sequences.
module tb_mem_access_bridge;
  import mem_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NO_ACK = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_read_i, mem_write_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o;
  logic          done_o, stall_o, err_o, proto_err_o;
  logic          bus_req_o, bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_ack_i;

  always #5 clk = ~clk;

  mem_access_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .done_o(done_o), .stall_o(stall_o), .err_o(err_o),
    .proto_err_o(proto_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          dly;       // WAIT cycles before ack; ack lands at cycle 1+dly
    int          exp_done;  // cycle of the done pulse, request sampled at cycle 0
    logic        exp_err;
    logic        hold_done; // raise mem_read during the DONE cycle
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] model_rdata;
  logic        model_proto;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] brdata,
                              input int dly, input int exp_done, input logic exp_err,
                              input logic hold_done);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.brdata = brdata;
    v.dly = dly; v.exp_done = exp_done; v.exp_err = exp_err; v.hold_done = hold_done;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    exp_t e, got_e;
    int   cyc;
    bit   got;
    @(posedge clk); #1;
    mem_read_i  = v.rd;
    mem_write_i = v.wr;
    addr_i      = v.addr;
    wdata_i     = v.wdata;
    if (v.rd && !v.wr && !v.exp_err) model_rdata = v.brdata;
    if (v.rd && v.wr) model_proto = 1'b1;
    e.rdata    = model_rdata;
    e.err      = v.exp_err;
    e.done_cyc = v.exp_done;
    sb.push_back(e);
    cyc = 0;
    got = 0;
    while (!got && cyc < v.exp_done + 5) begin
      @(posedge clk); #1;
      cyc++;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      addr_i      = 32'hBAD0_0000 + 32'(cyc);
      wdata_i     = 32'h0BAD_0000 + 32'(cyc);
      bus_ack_i   = (cyc == 1 + v.dly);
      bus_rdata_i = bus_ack_i ? v.brdata : 32'hDEAD_BEEF;
      if (done_o) begin
        got   = 1;
        got_e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(got_e.done_cyc));
        chk("rdata", rdata_o, got_e.rdata);
        chk("err", {31'd0, err_o}, {31'd0, got_e.err});
        chk("stall_in_done", {31'd0, stall_o}, 32'd0);
        chk("bus_req_in_done", {31'd0, bus_req_o}, 32'd0);
        if (v.hold_done) mem_read_i = 1'b1;
      end else if (cyc < v.exp_done) begin
        chk("stall_wait", {31'd0, stall_o}, 32'd1);
        chk("bus_req_wait", {31'd0, bus_req_o}, 32'd1);
        chk("bus_we", {31'd0, bus_we_o}, {31'd0, v.wr});
        chk("bus_addr", bus_addr_o, v.addr);
        chk("bus_wdata", bus_wdata_o, v.wdata);
      end
    end
    bus_ack_i = 1'b0;
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_missing: got no done within %0d cycles expected done at cycle %0d",
               v.exp_done + 5, v.exp_done);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    mem_read_i = 1'b0;
    chk("done_one_cycle", {31'd0, done_o}, 32'd0);
    chk("idle_stall", {31'd0, stall_o}, 32'd0);
    chk("idle_bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("proto_err", {31'd0, proto_err_o}, {31'd0, model_proto});
    if (v.hold_done) begin
      @(posedge clk); #1;
      chk("done_req_ignored_req", {31'd0, bus_req_o}, 32'd0);
      chk("done_req_ignored_stall", {31'd0, stall_o}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
    model_rdata = '0; model_proto = 1'b0;

    vecs.push_back(mk(1, 0, 32'h0000_0100, 32'h0,         32'hE3A0_1005, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0040, 32'h1234_5678, 32'h0,         4, 6, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0044, 32'h0,         32'hA5A5_0F0F, 2, 4, 0, 0));
    vecs.push_back(mk(1, 1, 32'h0000_0080, 32'hCAFE_F00D, 32'h1111_2222, 1, 3, 0, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0104, 32'h0,         32'h0000_0001, 0, 2, 0, 1));
    vecs.push_back(mk(1, 0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 7, 9, 0, 0));
`ifdef MEM_TIMEOUT_EN
    vecs.push_back(mk(1, 0, 32'h0000_0200, 32'h0,         32'h5A5A_5A5A, NO_ACK, 17, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0204, 32'h0,         32'h0BAD_CAFE, 15,     17, 0, 0));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err_o}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we_o}, 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_bus_wdata", bus_wdata_o, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Stray ack in IDLE must not start or complete anything.
    @(posedge clk); #1;
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    chk("stray_ack_done", {31'd0, done_o}, 32'd0);
    chk("stray_ack_stall", {31'd0, stall_o}, 32'd0);
    chk("stray_ack_bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("stray_ack_rdata", rdata_o, model_rdata);

    // Reset in WAIT: immediate abort, later ack ignored.
    @(posedge clk); #1;
    mem_read_i = 1'b1;
    addr_i = 32'h0000_0300;
    @(posedge clk); #1;
    mem_read_i = 1'b0;
    chk("pre_rst_bus_req", {31'd0, bus_req_o}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("mid_rst_proto_err", {31'd0, proto_err_o}, 32'd0);
    chk("mid_rst_rdata", rdata_o, 32'd0);
    model_rdata = '0;
    model_proto = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      chk("post_rst_done", {31'd0, done_o}, 32'd0);
      chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
      chk("post_rst_bus_req", {31'd0, bus_req_o}, 32'd0);
    end
    chk("post_rst_rdata", rdata_o, 32'd0);

    run_txn(mk(1, 0, 32'h0000_0400, 32'h0, 32'h0F1E_2D3C, 1, 3, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
